sar_adc_seq: RTL and testbench
==============================

# sar_adc_seq

Conversion sequencer and result conditioner sitting directly downstream of the 8-bit SAR ADC hard macro. Periodically pulses the ADC `start` pin and waits for end-of-conversion. Captures the 8-bit code, which the parent assembles from the macro's scalar `dout0..dout7` pins. Averages 2^AVG_LOG2 codes and presents the result on a valid/ready port feeding the SID pot-register logic.

## Interface
- DIV_W, 16, width of the sample-period counter and `period` port
- AVG_LOG2, 2, log2 of codes averaged per result (0 = no averaging; legal 0..4)
- TIMEOUT, 255, clock cycles allowed in CONV before a conversion is abandoned (≥2)

One clock; reset is synchronous and active-high.
- clk  in  1  system clock; ADC macro shares it
- rst  in  1  synchronous active-high reset
- en  in  1  sequencer enable
- period  in  DIV_W  cycles between ticks; 0 treated as 1
- adc_start  out  1  one-cycle start pulse to ADC `start`
- adc_eoc  in  1  ADC `eoc` (level; completion = rising edge)
- adc_dout  in  8  ADC code {dout7..dout0}, valid when eoc rises
- sample  out  8  averaged result
- sample_valid  out  1  result available
- sample_ready  in  1  consumer accepts result
- busy  out  1  high in START or CONV
- overrun  out  1  sticky: unconsumed result overwritten
- timeout_err  out  1  sticky: conversion timed out
- clr_err  in  1  clears both sticky flags

## Operation
- Reset values: adc_start 0, sample 0, sample_valid 0, busy 0, overrun 0, timeout_err 0; FSM IDLE; counters, accumulator, eoc_q all 0.
- Period counter: while en=1, counts down; at 0 asserts internal tick for one cycle and reloads max(period,1)-1. While en=0, held at 0, so the first tick comes in the first cycle en=1.
- Edge detect: eoc_q <= adc_eoc every cycle; eoc_edge = adc_eoc & ~eoc_q.
- FSM states:
  - IDLE: en=1 → WAIT.
  - WAIT: on tick → START.
  - START: adc_start=1 for exactly this cycle; clear timeout counter → CONV.
  - CONV: timeout counter increments each cycle.
    - On eoc_edge: accumulate adc_dout → WAIT.
    - Else at count TIMEOUT: set timeout_err, discard conversion (accumulator and sample count unchanged) → WAIT.
- Ticks arriving outside WAIT are dropped; the period counter free-runs.
- en=0 in any state: next state IDLE, adc_start 0, accumulator and sample count cleared. The output register and sticky flags are untouched.
- Accumulator: 8+AVG_LOG2 bits, never overflows. On capture acc_next = acc + adc_dout and sample count increments.
  - When the count reaches 2^AVG_LOG2: result = acc_next >> AVG_LOG2 (truncation), then acc and count clear.
- Output register:
  - New result loads `sample` and sets sample_valid.
  - A handshake (valid & ready) without a new result clears sample_valid.
  - New result while valid=1 and ready=0: sample overwritten, overrun set.
  - New result with valid=1 and ready=1 in the same cycle: old result consumed, new loaded, valid stays 1, no overrun.
- Sticky flags: clr_err clears them; a set event in the same cycle wins.

## Timing
- Tick in cycle T (from WAIT) → adc_start high in T+1, CONV from T+2.
- eoc_edge in cycle E → accumulator updated at E+1. For the final code of a group, sample/sample_valid are updated at E+1 (one-cycle latency).
- eoc high already at START (stale level) does not count; only a 0→1 transition does.
- Timeout: with no edge, timeout_err rises at START+TIMEOUT+1 and FSM is in WAIT the same cycle.
- period=1 (or 0): tick every cycle; conversions run back-to-back, one WAIT cycle between them.
- busy = (state==START)|(state==CONV), registered with the state.

## Test plan
- Reset: hold rst 3 cycles with en=1 and eoc toggling → all outputs 0, no adc_start; first adc_start 1 cycle after rst falls + tick.
- Averaging, AVG_LOG2=2, period=100, model returns 10,20,30,41 → sample=25 (101>>2), sample_valid 1 cycle after 4th eoc edge; exactly 4 adc_start pulses 100 cycles apart.
- Timeout, TIMEOUT=255, eoc stuck 0 → timeout_err=1 at START+256, no sample_valid; next code 200 with AVG_LOG2=0 → sample=200; clr_err → timeout_err=0.
- Overrun, AVG_LOG2=0, ready=0, codes 0x11 then 0x22 → sample=0x22, overrun=1. Repeat with ready=1 in the second result's load cycle → overrun stays 0, valid stays 1.
- en dropped in CONV after 2 of 4 codes (AVG_LOG2=2), re-enabled, codes 4×8 → sample=8 (partial sum discarded); busy=0 the cycle after en=0.
- Stale eoc: eoc held 1 across START, falls, rises 5 cycles later with code 0x7F → exactly one capture, sample=0x7F (AVG_LOG2=0).

Source files
------------

// File: rtl/sar_adc_seq.sv
// SAR ADC conversion sequencer: a periodic tick starts a conversion, the
// code is captured on the rising edge of eoc, 2^AVG_LOG2 codes are
// averaged, and the result is offered on a valid/ready port.
module sar_adc_seq #(
  parameter int DIV_W    = 16,
  parameter int AVG_LOG2 = 2,
  parameter int TIMEOUT  = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] period,
  output logic             adc_start,
  input  logic             adc_eoc,
  input  logic [7:0]       adc_dout,
  output logic [7:0]       sample,
  output logic             sample_valid,
  input  logic             sample_ready,
  output logic             busy,
  output logic             overrun,
  output logic             timeout_err,
  input  logic             clr_err
);

  localparam int ACC_W = 8 + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] GROUP   = CNT_W'(1 << AVG_LOG2);
  // The counter is 0 in the first CONV cycle, so TIMEOUT-1 marks the
  // TIMEOUT-th CONV cycle, the last one in which an edge is still accepted.
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WAIT, START, CONV} state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic             eoc_q;
  logic             eoc_edge;
  logic [TO_W-1:0]  to_cnt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_next;
  logic [CNT_W-1:0] n_cnt;
  logic [CNT_W-1:0] n_next;
  logic             capture;
  logic             group_done;
  logic             timeout_hit;
  logic [7:0]       result;

  assign tick        = en & (div_cnt == '0);
  assign eoc_edge    = adc_eoc & ~eoc_q;
  assign capture     = en & (state == CONV) & eoc_edge;
  assign timeout_hit = en & (state == CONV) & ~eoc_edge & (to_cnt == TO_LAST);
  assign acc_next    = acc + ACC_W'(adc_dout);
  assign n_next      = n_cnt + CNT_W'(1);
  assign group_done  = capture & (n_next == GROUP);
  assign result      = 8'(acc_next >> AVG_LOG2);

  // Sample-period down-counter; held at 0 while disabled so enabling ticks at once.
  always_ff @(posedge clk) begin
    if (rst || !en)
      div_cnt <= '0;
    else if (tick)
      div_cnt <= (period == '0) ? '0 : period - DIV_W'(1);
    else
      div_cnt <= div_cnt - DIV_W'(1);
  end

  // Delayed eoc for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) eoc_q <= 1'b0;
    else     eoc_q <= adc_eoc;
  end

  // Sequencer FSM with registered start/busy, timeout counter and accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      adc_start <= 1'b0;
      busy      <= 1'b0;
      to_cnt    <= '0;
      acc       <= '0;
      n_cnt     <= '0;
    end else if (!en) begin
      state     <= IDLE;
      adc_start <= 1'b0;
      busy      <= 1'b0;
      acc       <= '0;
      n_cnt     <= '0;
    end else begin
      adc_start <= 1'b0;
      busy      <= 1'b0;
      case (state)
        IDLE: state <= WAIT;
        WAIT: begin
          if (tick) begin
            state     <= START;
            adc_start <= 1'b1;
            busy      <= 1'b1;
          end
        end
        START: begin
          to_cnt <= '0;
          state  <= CONV;
          busy   <= 1'b1;
        end
        CONV: begin
          if (eoc_edge) begin
            state <= WAIT;
            if (n_next == GROUP) begin
              acc   <= '0;
              n_cnt <= '0;
            end else begin
              acc   <= acc_next;
              n_cnt <= n_next;
            end
          end else if (to_cnt == TO_LAST) begin
            state <= WAIT;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
            busy   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Result register, valid/ready handshake and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample       <= 8'd0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      if (group_done) begin
        sample       <= result;
        sample_valid <= 1'b1;
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end
      overrun     <= (group_done & sample_valid & ~sample_ready) | (overrun & ~clr_err);
      timeout_err <= timeout_hit | (timeout_err & ~clr_err);
    end
  end

endmodule

// File: tb/tb_sar_adc_seq.sv
// Self-checking bench for sar_adc_seq: one averaging instance (AVG_LOG2=2)
// and one pass-through instance (AVG_LOG2=0) share all stimulus.
module tb_sar_adc_seq;

  logic        clk = 1'b0;
  logic        rst, en, eoc, ready, clr;
  logic [15:0] period;
  logic [7:0]  dout;

  logic       a_start, a_valid, a_busy, a_ovr, a_to;
  logic [7:0] a_sample;
  logic       r_start, r_valid, r_busy, r_ovr, r_to;
  logic [7:0] r_sample;

  int cyc = 0;
  int pass_cnt = 0;
  int total = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sar_adc_seq #(.DIV_W(16), .AVG_LOG2(2), .TIMEOUT(255)) u_avg (
    .clk(clk), .rst(rst), .en(en), .period(period), .adc_start(a_start),
    .adc_eoc(eoc), .adc_dout(dout), .sample(a_sample), .sample_valid(a_valid),
    .sample_ready(ready), .busy(a_busy), .overrun(a_ovr), .timeout_err(a_to),
    .clr_err(clr));

  sar_adc_seq #(.DIV_W(16), .AVG_LOG2(0), .TIMEOUT(255)) u_raw (
    .clk(clk), .rst(rst), .en(en), .period(period), .adc_start(r_start),
    .adc_eoc(eoc), .adc_dout(dout), .sample(r_sample), .sample_valid(r_valid),
    .sample_ready(ready), .busy(r_busy), .overrun(r_ovr), .timeout_err(r_to),
    .clr_err(clr));

  task automatic do_reset(input logic [15:0] per);
    @(negedge clk);
    rst = 1; en = 1; period = per; eoc = 0; dout = 0; ready = 0; clr = 0;
    repeat (3) @(negedge clk);
    rst = 0;
  endtask

  // Returns at the negedge of the cycle in which adc_start is high.
  task automatic wait_start(output int s, output bit ok);
    ok = 0; s = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (r_start) begin ok = 1; s = cyc; break; end
    end
  endtask

  // ADC model: eoc rises lat cycles after start with the code, then drops.
  // Returns at the negedge one cycle after the edge cycle.
  task automatic serve(input logic [7:0] code, input int lat, output int s, output bit ok);
    wait_start(s, ok);
    if (ok) begin
      repeat (lat) @(negedge clk);
      eoc = 1; dout = code;
      @(negedge clk);
      eoc = 0;
    end
  endtask

  task automatic test_reset();
    int k;
    bit found;
    @(negedge clk);
    rst = 1; en = 1; period = 100; ready = 0; clr = 0; dout = 8'h5A; eoc = 0;
    for (int i = 0; i < 3; i++) begin
      eoc = ~eoc;
      @(negedge clk);
      total++;
      if ({a_start, a_sample, a_valid, a_busy, a_ovr, a_to, r_start, r_sample, r_valid, r_busy, r_ovr, r_to} !== '0)
        $display("FAIL reset_outputs cycle %0d: got %h %h / %h %h required all 0", i,
                 a_sample, {a_start, a_valid, a_busy, a_ovr, a_to}, r_sample, {r_start, r_valid, r_busy, r_ovr, r_to});
      else pass_cnt++;
    end
    rst = 0; eoc = 0;
    k = 0; found = 0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (r_start) begin k = i; found = 1; break; end
    end
    // Enable tick while in IDLE is dropped; next tick 100 cycles later.
    total++;
    if (!found || k != 101) $display("FAIL first_start: got cycle %0d (found=%0d) required 101", k, found);
    else pass_cnt++;
    total++;
    if (r_busy !== 1'b1) $display("FAIL busy_in_start: got %b required 1", r_busy);
    else pass_cnt++;
  endtask

  task automatic test_averaging();
    int codes[4] = '{10, 20, 30, 41};
    int starts[4];
    int sum;
    bit ok;
    logic [7:0] exp;
    do_reset(100);
    ready = 1; sum = 0;
    for (int i = 0; i < 4; i++) begin
      serve(8'(codes[i]), 5, starts[i], ok);
      total++;
      if (!ok) $display("FAIL avg_start_seen %0d: got none required a start", i); else pass_cnt++;
      sum += codes[i];
      if (i > 0) begin
        total++;
        if (starts[i] - starts[i-1] != 100)
          $display("FAIL avg_start_spacing %0d: got %0d required 100", i, starts[i] - starts[i-1]);
        else pass_cnt++;
      end
      if (i < 3) begin
        total++;
        if (a_valid !== 1'b0) $display("FAIL avg_early_valid %0d: got %b required 0", i, a_valid);
        else pass_cnt++;
      end
    end
    exp = 8'(sum / 4);
    total++;
    if (a_valid !== 1'b1 || a_sample !== exp)
      $display("FAIL avg_result: got valid=%b sample=%0d required valid=1 sample=%0d", a_valid, a_sample, exp);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    int s;
    bit ok, seen_v;
    do_reset(1);
    ready = 0; seen_v = 0;
    wait_start(s, ok);
    total++;
    if (!ok) $display("FAIL to_start_seen: got none required a start"); else pass_cnt++;
    for (int k = 1; k <= 256; k++) begin
      @(negedge clk);
      if (r_valid) seen_v = 1;
      if (k == 255) begin
        total++;
        if (r_to !== 1'b0) $display("FAIL to_early: got %b required 0", r_to); else pass_cnt++;
      end
      if (k == 256) begin
        total++;
        if (r_to !== 1'b1 || a_to !== 1'b1 || r_busy !== 1'b0)
          $display("FAIL to_flag: got to=%b/%b busy=%b required 1/1 0", r_to, a_to, r_busy);
        else pass_cnt++;
      end
    end
    total++;
    if (seen_v) $display("FAIL to_no_valid: got valid during timeout required none"); else pass_cnt++;
    serve(8'd200, 3, s, ok);
    total++;
    if (!ok || r_valid !== 1'b1 || r_sample !== 8'd200 || a_valid !== 1'b0)
      $display("FAIL to_recover: got ok=%0d valid=%b sample=%0d avg_valid=%b required 1 1 200 0", ok, r_valid, r_sample, a_valid);
    else pass_cnt++;
    clr = 1;
    @(negedge clk);
    clr = 0;
    total++;
    if (r_to !== 1'b0 || a_to !== 1'b0) $display("FAIL to_clear: got %b/%b required 0/0", r_to, a_to);
    else pass_cnt++;
  endtask

  task automatic test_overrun();
    int s;
    bit ok;
    do_reset(1);
    ready = 0;
    serve(8'h11, 2, s, ok);
    total++;
    if (!ok || r_valid !== 1'b1 || r_sample !== 8'h11 || r_ovr !== 1'b0)
      $display("FAIL ovr_first: got valid=%b sample=%h ovr=%b required 1 11 0", r_valid, r_sample, r_ovr);
    else pass_cnt++;
    serve(8'h22, 2, s, ok);
    total++;
    if (!ok || r_valid !== 1'b1 || r_sample !== 8'h22 || r_ovr !== 1'b1)
      $display("FAIL ovr_second: got valid=%b sample=%h ovr=%b required 1 22 1", r_valid, r_sample, r_ovr);
    else pass_cnt++;
    clr = 1;
    @(negedge clk);
    clr = 0;
    total++;
    if (r_ovr !== 1'b0) $display("FAIL ovr_clear: got %b required 0", r_ovr); else pass_cnt++;
    // New result with a same-cycle handshake: no overrun, valid stays high.
    wait_start(s, ok);
    repeat (2) @(negedge clk);
    eoc = 1; dout = 8'h33; ready = 1;
    @(negedge clk);
    eoc = 0; ready = 0;
    total++;
    if (!ok || r_valid !== 1'b1 || r_sample !== 8'h33 || r_ovr !== 1'b0)
      $display("FAIL ovr_handshake_load: got valid=%b sample=%h ovr=%b required 1 33 0", r_valid, r_sample, r_ovr);
    else pass_cnt++;
    ready = 1;
    @(negedge clk);
    ready = 0;
    total++;
    if (r_valid !== 1'b0) $display("FAIL ovr_consume: got valid=%b required 0", r_valid); else pass_cnt++;
  endtask

  task automatic test_en_drop();
    int s;
    bit ok;
    do_reset(1);
    ready = 1;
    for (int i = 0; i < 2; i++) serve(8'd100, 3, s, ok);
    wait_start(s, ok);
    @(negedge clk);
    total++;
    if (!ok || a_busy !== 1'b1) $display("FAIL endrop_busy_conv: got %b required 1", a_busy); else pass_cnt++;
    en = 0;
    @(negedge clk);
    total++;
    if (a_busy !== 1'b0 || a_start !== 1'b0)
      $display("FAIL endrop_busy_off: got busy=%b start=%b required 0 0", a_busy, a_start);
    else pass_cnt++;
    repeat (3) @(negedge clk);
    en = 1;
    for (int i = 0; i < 4; i++) begin
      serve(8'd8, 2, s, ok);
      total++;
      if (!ok) $display("FAIL endrop_start_seen %0d: got none required a start", i); else pass_cnt++;
    end
    total++;
    if (a_valid !== 1'b1 || a_sample !== 8'd8)
      $display("FAIL endrop_result: got valid=%b sample=%0d required 1 8", a_valid, a_sample);
    else pass_cnt++;
  endtask

  task automatic test_stale_eoc();
    int s;
    bit ok;
    do_reset(1);
    ready = 0;
    eoc = 1; dout = 8'h01;
    wait_start(s, ok);
    @(negedge clk);
    @(negedge clk);
    eoc = 0;
    repeat (5) @(negedge clk);
    total++;
    if (!ok || r_valid !== 1'b0) $display("FAIL stale_no_capture: got valid=%b required 0", r_valid); else pass_cnt++;
    eoc = 1; dout = 8'h7F;
    @(negedge clk);
    eoc = 0;
    repeat (3) @(negedge clk);
    total++;
    if (r_valid !== 1'b1 || r_sample !== 8'h7F || r_ovr !== 1'b0)
      $display("FAIL stale_single_capture: got valid=%b sample=%h ovr=%b required 1 7f 0", r_valid, r_sample, r_ovr);
    else pass_cnt++;
  endtask

  task automatic test_random();
    int s, lat, sum, n;
    bit ok;
    logic [7:0] code, exp;
    do_reset(16'($urandom_range(1, 6)));
    ready = 1; sum = 0; n = 0;
    for (int i = 0; i < 12; i++) begin
      code = 8'($urandom_range(0, 255));
      lat = (i == 0) ? 255 : $urandom_range(1, 30);
      serve(code, lat, s, ok);
      sum += code; n++;
      total++;
      if (!ok || r_valid !== 1'b1 || r_sample !== code || r_to !== 1'b0)
        $display("FAIL rand_raw %0d: got ok=%0d valid=%b sample=%0d to=%b required 1 1 %0d 0", i, ok, r_valid, r_sample, r_to, code);
      else pass_cnt++;
      if (n == 4) begin
        exp = 8'(sum / 4);
        total++;
        if (a_valid !== 1'b1 || a_sample !== exp)
          $display("FAIL rand_avg %0d: got valid=%b sample=%0d required 1 %0d", i, a_valid, a_sample, exp);
        else pass_cnt++;
        sum = 0; n = 0;
      end else begin
        total++;
        if (a_valid !== 1'b0) $display("FAIL rand_avg_idle %0d: got valid=%b required 0", i, a_valid);
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    rst = 1; en = 0; period = 0; eoc = 0; dout = 0; ready = 0; clr = 0;
    test_reset();
    test_averaging();
    test_timeout();
    test_overrun();
    test_en_drop();
    test_stale_eoc();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", pass_cnt, total);
    $fatal(1, "watchdog");
  end

endmodule
